// File: rtl/vga_text_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_text_pkg
// Brief    : Shared geometry defaults, control codes and writer state type.
// Revision : 1.0
// ============================================================================
package vga_text_pkg;

   localparam int COLS_DEFAULT = 80;
   localparam int ROWS_DEFAULT = 30;

   localparam logic [7:0] CH_SPACE    = 8'h20;
   localparam logic [7:0] CH_LF       = 8'h0A;
   localparam logic [7:0] CH_CR       = 8'h0D;
   localparam logic [7:0] CH_BS       = 8'h08;
   localparam logic [7:0] CH_FF       = 8'h0C;
   localparam logic [7:0] CH_TAB      = 8'h09;
   localparam logic [7:0] CH_PRINT_LO = 8'h20;
   localparam logic [7:0] CH_PRINT_HI = 8'h7E;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      CLR_ROW    = 2'd1,
      CLR_SCREEN = 2'd2
   } writer_state_t;

   function automatic logic is_printable(input logic [7:0] ch);
      return (ch >= CH_PRINT_LO) && (ch <= CH_PRINT_HI);
   endfunction

endpackage : vga_text_pkg
`default_nettype wire

// File: rtl/vga_cursor.sv
`default_nettype none
// ============================================================================
// Module   : vga_cursor
// Brief    : Cursor column/row, row base and linear address with all wrap logic.
// Revision : 1.0
// ============================================================================
module vga_cursor
   import vga_text_pkg::*;
#(
   parameter int COLS  = COLS_DEFAULT,
   parameter int ROWS  = ROWS_DEFAULT,
   parameter int COL_W = $clog2(COLS),
   parameter int ROW_W = $clog2(ROWS),
   parameter int LIN_W = $clog2(COLS * ROWS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             newline,
   input  logic             home,
   input  logic             back,
   input  logic             cret,
   input  logic             tab,
   output logic [COL_W-1:0] cursor_x,
   output logic [ROW_W-1:0] cursor_y,
   output logic [LIN_W-1:0] row_base,
   output logic [LIN_W-1:0] lin_addr,
   output logic             row_adv
);

   logic [COL_W-1:0] r_x;
   logic [ROW_W-1:0] r_y;
   logic [LIN_W-1:0] r_base;
   logic [LIN_W-1:0] r_lin;

   logic             w_last_col;
   logic             w_last_row;
   logic             w_tab_wrap;
   logic [COL_W:0]   w_tab_stop;
   logic [LIN_W-1:0] w_next_base;

   assign w_last_col  = (r_x == COL_W'(COLS - 1));
   assign w_last_row  = (r_y == ROW_W'(ROWS - 1));

   // Next multiple of 8, one bit wider so a stop at or past COLS is detectable.
   assign w_tab_stop  = {1'b0, r_x | COL_W'(7)} + (COL_W + 1)'(1);
   assign w_tab_wrap  = tab && (w_tab_stop >= (COL_W + 1)'(COLS));

   assign row_adv     = newline || (inc && w_last_col) || w_tab_wrap;
   assign w_next_base = w_last_row ? '0 : r_base + LIN_W'(COLS);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_x    <= '0;
         r_y    <= '0;
         r_base <= '0;
         r_lin  <= '0;
      end else if (home) begin
         r_x    <= '0;
         r_y    <= '0;
         r_base <= '0;
         r_lin  <= '0;
      end else if (row_adv) begin
         r_x    <= '0;
         r_y    <= w_last_row ? '0 : r_y + ROW_W'(1);
         r_base <= w_next_base;
         r_lin  <= w_next_base;
      end else if (inc) begin
         r_x    <= r_x + COL_W'(1);
         r_lin  <= r_lin + LIN_W'(1);
      end else if (back && (r_x != '0)) begin
         r_x    <= r_x - COL_W'(1);
         r_lin  <= r_lin - LIN_W'(1);
      end else if (cret) begin
         r_x    <= '0;
         r_lin  <= r_base;
      end else if (tab) begin
         r_x    <= w_tab_stop[COL_W-1:0];
         r_lin  <= r_base + LIN_W'(w_tab_stop);
      end
   end

   assign cursor_x = r_x;
   assign cursor_y = r_y;
   assign row_base = r_base;
   assign lin_addr = r_lin;

endmodule : vga_cursor
`default_nettype wire

// File: rtl/vga_text_writer.sv
`default_nettype none
// ============================================================================
// Module   : vga_text_writer
// Brief    : Byte-stream writer into the text buffer with terminal control
//            codes and row/screen clears. Option: VGA_WRITER_TAB_EN (TAB stops).
// Revision : 1.0
// ============================================================================
module vga_text_writer
   import vga_text_pkg::*;
#(
   parameter  int COLS   = COLS_DEFAULT,
   parameter  int ROWS   = ROWS_DEFAULT,
   parameter  int ADDR_W = 32,
   localparam int COL_W  = $clog2(COLS),
   localparam int ROW_W  = $clog2(ROWS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        char_in,
   input  logic              char_valid,
   output logic              char_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic [COL_W-1:0]  cursor_x,
   output logic [ROW_W-1:0]  cursor_y
);

   localparam int               LIN_W         = $clog2(COLS * ROWS);
   localparam logic [LIN_W-1:0] C_ROW_LAST    = LIN_W'(COLS - 1);
   localparam logic [LIN_W-1:0] C_SCREEN_LAST = LIN_W'(COLS * ROWS - 1);

   writer_state_t    r_state;
   logic [LIN_W-1:0] r_clr_cnt;

   logic             w_accept;
   logic             w_inc;
   logic             w_newline;
   logic             w_home;
   logic             w_back;
   logic             w_cret;
   logic             w_tab;
   logic             w_row_adv;
   logic [LIN_W-1:0] w_row_base;
   logic [LIN_W-1:0] w_lin_addr;

   assign char_ready = (r_state == IDLE);
   assign w_accept   = char_valid && char_ready;

   assign w_inc      = w_accept && is_printable(char_in);
   assign w_newline  = w_accept && (char_in == CH_LF);
   assign w_home     = w_accept && (char_in == CH_FF);
   assign w_back     = w_accept && (char_in == CH_BS);
   assign w_cret     = w_accept && (char_in == CH_CR);

`ifdef VGA_WRITER_TAB_EN
   assign w_tab      = w_accept && (char_in == CH_TAB);
`else
   assign w_tab      = 1'b0;
`endif

   vga_cursor #(
      .COLS    (COLS),
      .ROWS    (ROWS),
      .COL_W   (COL_W),
      .ROW_W   (ROW_W),
      .LIN_W   (LIN_W)
   ) u_cursor (
      .clk     (clk),
      .reset   (reset),
      .inc     (w_inc),
      .newline (w_newline),
      .home    (w_home),
      .back    (w_back),
      .cret    (w_cret),
      .tab     (w_tab),
      .cursor_x(cursor_x),
      .cursor_y(cursor_y),
      .row_base(w_row_base),
      .lin_addr(w_lin_addr),
      .row_adv (w_row_adv)
   );

   // Clear states emit one space per edge; the edge that registers the last
   // write also returns to IDLE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= CLR_SCREEN;
         r_clr_cnt <= '0;
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
      end else begin
         wr_en <= 1'b0;
         case (r_state)
            IDLE: begin
               r_clr_cnt <= '0;
               if (w_inc) begin
                  wr_en   <= 1'b1;
                  wr_addr <= ADDR_W'(w_lin_addr);
                  wr_data <= char_in;
               end else if (w_back && (cursor_x != '0)) begin
                  wr_en   <= 1'b1;
                  wr_addr <= ADDR_W'(w_lin_addr - LIN_W'(1));
                  wr_data <= CH_SPACE;
               end
               if (w_home) begin
                  r_state <= CLR_SCREEN;
               end else if (w_row_adv) begin
                  r_state <= CLR_ROW;
               end
            end

            CLR_ROW: begin
               wr_en   <= 1'b1;
               wr_addr <= ADDR_W'(w_row_base + r_clr_cnt);
               wr_data <= CH_SPACE;
               if (r_clr_cnt == C_ROW_LAST) begin
                  r_state   <= IDLE;
                  r_clr_cnt <= '0;
               end else begin
                  r_clr_cnt <= r_clr_cnt + LIN_W'(1);
               end
            end

            CLR_SCREEN: begin
               wr_en   <= 1'b1;
               wr_addr <= ADDR_W'(r_clr_cnt);
               wr_data <= CH_SPACE;
               if (r_clr_cnt == C_SCREEN_LAST) begin
                  r_state   <= IDLE;
                  r_clr_cnt <= '0;
               end else begin
                  r_clr_cnt <= r_clr_cnt + LIN_W'(1);
               end
            end

            default: begin
               r_state   <= IDLE;
               r_clr_cnt <= '0;
            end
         endcase
      end
   end

endmodule : vga_text_writer
`default_nettype wire
